pwm_setting_control: RTL and testbench
======================================

# pwm_setting_control

User-input front end of the PWM controller: debounces two push-buttons (up/down) and maintains the frequency setting `iF` and current setting `iC` that the display and PWM blocks consume. The `switch` input selects which setting the buttons edit, matching the selection the display shows. Settings change by one step per debounced press and saturate at the ends of their ranges.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- `IF_MAX`, default 7: upper limit of `iF`.
- `IC_MAX`, default 10: upper limit of `iC`.
- `REPEAT_DELAY`, default 25000000: hold time before auto-repeat starts. Used only with `AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat steps. Used only with `AUTOREPEAT_EN`.

Ports:
- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_up`  in  1  raw asynchronous button, high = pressed.
- `btn_down`  in  1  raw asynchronous button, high = pressed.
- `switch`  in  1  0 = buttons edit `iF`; 1 = buttons edit `iC`.
- `iF`  out  3  frequency setting, 0..`IF_MAX`.
- `iC`  out  4  current setting, 0..`IC_MAX`.
- `changed`  out  1  one-cycle pulse in the cycle after `iF` or `iC` took a new value.

## Operation
- Each button passes through a 2-FF synchronizer, then a debounce FSM.
- Debounce FSM states and transitions:
  - RELEASED goes to CONFIRM_PRESS when the synchronized input is 1.
  - CONFIRM_PRESS counts while the input is 1. When the count reaches `DEBOUNCE_CYCLES`, go to PRESSED and emit a 1-cycle `press` pulse. If the input is 0 first, return to RELEASED and clear the counter.
  - PRESSED goes to CONFIRM_RELEASE when the input is 0.
  - CONFIRM_RELEASE counts while the input is 0. When the count reaches `DEBOUNCE_CYCLES`, go to RELEASED. If the input is 1 first, return to PRESSED.
- The counter is 0 at every state entry. Its width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Update rules, applied in the cycle of a `press` pulse:
  - The target register is chosen by `switch` as sampled in that same cycle.
  - `up` increments the target unless it equals its MAX. `down` decrements it unless it is 0. Saturation, never wrap.
- If `up` and `down` pulse in the same cycle, nothing changes and `changed` stays 0.
- A press at saturation gives no value change and no `changed` pulse.
- `changed` pulses only when a value actually changed.
- Outputs are registered directly; there is no combinational path from inputs to outputs.

## Timing
- Reset values: `iF`=0, `iC`=0, `changed`=0, both FSMs in RELEASED, all counters 0.
- Latency: a clean press sampled high at clock edge N updates `iF`/`iC` at edge N+2+`DEBOUNCE_CYCLES`+1. `changed` is high for the cycle after that edge.
- Glitch rejection: a pulse shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no update.
- Reset asserted mid-debounce aborts it. A button still held when reset deasserts must complete a full debounce, then counts as one press.
- Toggling `switch` while a button is held does not retarget the press that was already taken. Only the pulse-cycle sample of `switch` matters.

## Configuration
- Macro `PWM_SETTING_AUTOREPEAT_EN`.
- When defined:
  - While a button stays in PRESSED, a repeat counter runs.
  - After `REPEAT_DELAY` cycles it emits a repeat pulse, then one every `REPEAT_PERIOD` cycles until the button leaves PRESSED.
  - Repeat pulses follow the same update rules as `press`, including saturation and simultaneous-button cancel.
- When undefined: one step per press only; the repeat logic and both repeat parameters are unused.

## Structure
- Package `pwm_setting_pkg` holds:
  - the debounce state enum (RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE);
  - the widths `IF_W`=3 and `IC_W`=4.
- One sub-module, `debounce_button`, contains the synchronizer, the debounce FSM and the optional repeat counter. It is instanced twice (up, down).
- The top level holds the settings registers, the select/saturation logic and `changed`.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4, `IF_MAX`=7, `IC_MAX`=10.
- Reset, then hold `btn_up` for 20 cycles with `switch`=0 -> `iF`=1 exactly 7 cycles after the first sampled high, `changed` pulses once, `iC`=0.
- A 3-cycle glitch on `btn_down`, then 8 presses of `btn_up` with `switch`=1 -> the glitch is ignored and `iC`=8.
- 12 presses of `btn_up` with `switch`=1 -> `iC` saturates at 10. Later presses give no `changed` pulse.
- `btn_down` pressed at `iF`=0 -> `iF` stays 0 and no `changed` pulse.
- Both buttons raised in the same cycle -> simultaneous pulses, no change to `iF`/`iC`.
- Assert reset in the middle of CONFIRM_PRESS while holding `btn_up`, release reset -> outputs are 0 during reset, then one increment occurs after a full debounce. With `PWM_SETTING_AUTOREPEAT_EN` and short repeat parameters: a held button steps repeatedly and saturates at MAX.

Source files
------------

// File: rtl/pwm_setting_pkg.sv
// Shared types and widths for the PWM settings front end.
package pwm_setting_pkg;

    localparam int unsigned IF_W = 3;
    localparam int unsigned IC_W = 4;

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } db_state_e;

    // Step request presented to the settings registers, one bit per button.
    typedef struct packed {
        logic up;
        logic dn;
    } step_req_t;

endpackage

// File: rtl/debounce_button.sv
// One push-button: 2-FF synchronizer, debounce FSM and, when
// PWM_SETTING_AUTOREPEAT_EN is defined, a hold-to-repeat counter.
// press is a one-cycle pulse built only from registered state.
module debounce_button
    import pwm_setting_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef PWM_SETTING_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_s;
    logic             db_press;

    assign btn_s = sync_q[1];

    // Synchronizer shift: sync_q[1] is the metastability-safe level.
    always_comb begin
        sync_d = {sync_q[0], btn};
    end

    // Debounce next state; the counter falls back to 0 on every state change.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        db_press = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_s) state_d = CONFIRM_PRESS;
            end
            CONFIRM_PRESS: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LIM) begin
                    state_d  = PRESSED;
                    db_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) state_d = CONFIRM_RELEASE;
            end
            CONFIRM_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LIM) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PWM_SETTING_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RD_LIM = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LIM = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;
    logic             rpt_pulse;

    // Hold timer: first step after the delay, then one per period while held.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_pulse   = 1'b0;
        if (state_q == PRESSED && btn_s) begin
            rpt_armed_d = rpt_armed_q;
            if (rpt_cnt_q == (rpt_armed_q ? RP_LIM : RD_LIM)) begin
                rpt_pulse   = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    // Initial press and repeat steps share one pulse output.
    always_comb begin
        press = db_press | rpt_pulse;
    end
`else
    // Only the debounced press produces a step.
    always_comb begin
        press = db_press;
    end
`endif

endmodule

// File: rtl/pwm_setting_control.sv
// Settings registers iF / iC driven by two debounced buttons. switch picks
// the target register; steps saturate at 0 and at the MAX parameters.
// Optional hold-to-repeat stepping is enabled by PWM_SETTING_AUTOREPEAT_EN.
module pwm_setting_control
    import pwm_setting_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned IF_MAX          = 7,
    parameter int unsigned IC_MAX          = 10,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            switch,
    output logic [IF_W-1:0] iF,
    output logic [IC_W-1:0] iC,
    output logic            changed
);

    localparam logic [IF_W-1:0] IF_LIM = IF_W'(IF_MAX);
    localparam logic [IC_W-1:0] IC_LIM = IC_W'(IC_MAX);

    step_req_t       req;
    logic [IF_W-1:0] if_q, if_d;
    logic [IC_W-1:0] ic_q, ic_d;
    logic            changed_q, changed_d;

`ifdef PWM_SETTING_AUTOREPEAT_EN
    debounce_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db_up (.clock(clock), .reset(reset), .btn(btn_up), .press(req.up));

    debounce_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db_dn (.clock(clock), .reset(reset), .btn(btn_down), .press(req.dn));
`else
    // Repeat timing has no effect in this build; a zero value would be
    // meaningless if repeat stepping were enabled, so flag it structurally.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_rpt_cfg_zero
    end

    debounce_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (.clock(clock), .reset(reset), .btn(btn_up), .press(req.up));

    debounce_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_dn (.clock(clock), .reset(reset), .btn(btn_down), .press(req.dn));
`endif

    // Apply one saturating step to the selected register; simultaneous
    // up and down cancel. changed flags an actual value change only.
    always_comb begin
        if_d      = if_q;
        ic_d      = ic_q;
        changed_d = 1'b0;
        if (req.up ^ req.dn) begin
            if (!switch) begin
                if (req.up && if_q != IF_LIM)   if_d = if_q + 1'b1;
                else if (req.dn && if_q != '0)  if_d = if_q - 1'b1;
            end else begin
                if (req.up && ic_q != IC_LIM)   ic_d = ic_q + 1'b1;
                else if (req.dn && ic_q != '0)  ic_d = ic_q - 1'b1;
            end
        end
        changed_d = (if_d != if_q) || (ic_d != ic_q);
    end

    // Settings and change-flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_q      <= '0;
            ic_q      <= '0;
            changed_q <= 1'b0;
        end else begin
            if_q      <= if_d;
            ic_q      <= ic_d;
            changed_q <= changed_d;
        end
    end

    assign iF      = if_q;
    assign iC      = ic_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_pwm_setting_control.sv
// Bench for pwm_setting_control with a debounce time of 4 cycles.
// The reference treats each synchronized button as a level that flips after
// DB+2 consecutive disagreeing samples; repeat steps (when
// PWM_SETTING_AUTOREPEAT_EN is defined) are derived from hold length.
module tb_pwm_setting_control;
    import pwm_setting_pkg::*;

    localparam int DB  = 4;
    localparam int IFM = 7;
    localparam int ICM = 10;
    localparam int RD  = 20;
    localparam int RP  = 6;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic switch   = 1'b0;
    logic [IF_W-1:0] iF;
    logic [IC_W-1:0] iC;
    logic changed;

    int vec      = 0;
    int miss     = 0;
    int chg_seen = 0;

    // reference state
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_lvl[2];
    int   m_run[2];
    int   m_h  [2];
    int   m_if;
    int   m_ic;
    logic m_chg;

    pwm_setting_control #(
        .DEBOUNCE_CYCLES(DB),
        .IF_MAX         (IFM),
        .IC_MAX         (ICM),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .switch  (switch),
        .iF      (iF),
        .iC      (iC),
        .changed (changed)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0;
            m_run[b] = 0;   m_h[b] = 0;
        end
        m_if  = 0;
        m_ic  = 0;
        m_chg = 1'b0;
    endtask

    // Effect of the coming rising edge, given the inputs it will sample.
    task automatic mdl_step();
        logic pulse[2];
        logic btn[2];
        logic up, dn;
`ifdef PWM_SETTING_AUTOREPEAT_EN
        logic held;
`endif
        btn[0] = btn_up;
        btn[1] = btn_down;
        for (int b = 0; b < 2; b++) begin
            pulse[b] = 1'b0;
`ifdef PWM_SETTING_AUTOREPEAT_EN
            held = m_lvl[b] && (m_run[b] == 0) && m_s2[b];
`endif
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB + 2) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                    pulse[b] = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
`ifdef PWM_SETTING_AUTOREPEAT_EN
            if (held) begin
                m_h[b]++;
                if (m_h[b] == RD || (m_h[b] > RD && (m_h[b] - RD) % RP == 0)) pulse[b] = 1'b1;
            end else begin
                m_h[b] = 0;
            end
`endif
        end
        up    = pulse[0] && !pulse[1];
        dn    = pulse[1] && !pulse[0];
        m_chg = 1'b0;
        if (!switch) begin
            if (up && m_if < IFM) begin m_if++; m_chg = 1'b1; end
            if (dn && m_if > 0)   begin m_if--; m_chg = 1'b1; end
        end else begin
            if (up && m_ic < ICM) begin m_ic++; m_chg = 1'b1; end
            if (dn && m_ic > 0)   begin m_ic--; m_chg = 1'b1; end
        end
        for (int b = 0; b < 2; b++) begin
            m_s2[b] = m_s1[b];
            m_s1[b] = btn[b];
        end
    endtask

    // Every falling edge: compare outputs with the reference, then advance it.
    initial forever begin
        @(negedge clock);
        if (reset) mdl_reset();
        check("iF", 32'(iF), 32'(m_if));
        check("iC", 32'(iC), 32'(m_ic));
        check("changed", 32'(changed), 32'(m_chg));
        if (changed === 1'b1) chg_seen++;
        if (!reset) mdl_step();
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tap(input bit up, input int hold);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        cyc(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(10);
    endtask

    initial begin
        int c0, c1;

        // reset state
        cyc(3);
        check("rst_iF", 32'(iF), 0);
        check("rst_iC", 32'(iC), 0);
        check("rst_changed", 32'(changed), 0);
        reset = 1'b0;
        cyc(2);

        // held button, switch=0: latency of 7 edges from first sample
        c0 = chg_seen;
        btn_up = 1'b1;
        cyc(7);
        check("lat_before", 32'(iF), 0);
        cyc(1);
        check("lat_iF", 32'(iF), 1);
        check("lat_changed", 32'(changed), 1);
        cyc(1);
        check("lat_changed_drop", 32'(changed), 0);
        cyc(11);
        btn_up = 1'b0;
        cyc(12);
        check("hold_iF", 32'(iF), 1);
        check("hold_iC", 32'(iC), 0);
        check("hold_pulses", 32'(chg_seen - c0), 1);

        // glitch on down, then 8 up presses into iC
        switch   = 1'b1;
        btn_down = 1'b1;
        cyc(3);
        btn_down = 1'b0;
        cyc(10);
        check("glitch_iC", 32'(iC), 0);
        repeat (8) tap(1'b1, 8);
        check("eight_iC", 32'(iC), 8);
        check("eight_iF", 32'(iF), 1);

        // saturation at IC_MAX
        c0 = chg_seen;
        repeat (2) tap(1'b1, 8);
        c1 = chg_seen;
        repeat (10) tap(1'b1, 8);
        check("sat_iC", 32'(iC), 10);
        check("sat_pulses_to_max", 32'(c1 - c0), 2);
        check("sat_pulses_at_max", 32'(chg_seen - c1), 0);

        // down to 0 and below on iF
        switch = 1'b0;
        tap(1'b0, 8);
        check("down_iF", 32'(iF), 0);
        c0 = chg_seen;
        tap(1'b0, 8);
        check("floor_iF", 32'(iF), 0);
        check("floor_pulses", 32'(chg_seen - c0), 0);

        // both buttons together cancel
        c0 = chg_seen;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cyc(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(12);
        check("both_iF", 32'(iF), 0);
        check("both_iC", 32'(iC), 10);
        check("both_pulses", 32'(chg_seen - c0), 0);

        // reset in the middle of a press while still holding
        btn_up = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(2);
        check("midrst_iF", 32'(iF), 0);
        check("midrst_iC", 32'(iC), 0);
        check("midrst_changed", 32'(changed), 0);
        reset = 1'b0;
        cyc(7);
        check("midrst_before", 32'(iF), 0);
        cyc(1);
        check("midrst_iF_after", 32'(iF), 1);
        check("midrst_changed_after", 32'(changed), 1);
        btn_up = 1'b0;
        cyc(12);

`ifdef PWM_SETTING_AUTOREPEAT_EN
        // held button repeats and saturates
        switch = 1'b1;
        btn_up = 1'b1;
        cyc(120);
        check("rpt_iC", 32'(iC), 10);
        btn_up = 1'b0;
        cyc(12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
